// File: rtl/crc_frame_ctrl_pkg.sv
// Shared types and constants for the CRC-8 frame controller and its byte serializer.
package crc_ctrl_pkg;

  localparam int CRC_W     = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/crc_frame_ctrl_if.sv
// Byte stream into the CRC frame controller: valid/ready handshake with an end-of-frame marker.
interface crc_frame_ctrl_if;
  import crc_ctrl_pkg::*;

  logic [CRC_W-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);

endinterface

// File: rtl/crc_frame_ctrl_byte_serializer.sv
// Shift register plus one-deep hold register; turns accepted bytes into an MSB-first bit stream.
module crc_byte_serializer
  import crc_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             push,
  input  logic             advance,
  input  logic [CRC_W-1:0] data,
  output logic             bit_out,
  output logic             last_bit,
  output logic             hold_full
);

  logic [CRC_W-1:0]     shift;
  logic [CRC_W-1:0]     hold;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // NOTE: the data registers are reset too, so an aborted frame can never leak stale bits into the next one.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (load) begin
        shift   <= data;
        bit_cnt <= '0;
      end else if (advance) begin
        if (last_bit && hold_full) begin
          shift     <= hold;
          bit_cnt   <= '0;
          hold_full <= 1'b0;
        end else begin
          shift   <= shift << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // Push only happens with the hold register empty, so it never races the drain above.
      if (push) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
    end
  end

  assign bit_out  = shift[CRC_W-1];
  assign last_bit = &bit_cnt;

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a bit-serial CRC-8 engine: feeds bytes MSB first, owns the engine reset,
// captures the final CRC and reports done/match or an aborted frame.
module crc_frame_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int               MAX_BYTES = 64,
  parameter int               CNT_W     = $clog2(MAX_BYTES + 1),
  parameter logic [CRC_W-1:0] RESIDUE   = 8'h00
) (
  input  logic             clock,
  input  logic             reset,
  crc_frame_ctrl_if.slave  stream,
  output logic             eng_bit,
  output logic             eng_reset,
  input  logic [CRC_W-1:0] eng_crc,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_ok,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t state;
  logic   last_seen;
  logic   accept;
  logic   in_idle;
  logic   in_shift;
  logic   ser_bit;
  logic   last_bit;
  logic   hold_full;

  assign in_idle  = (state == IDLE);
  assign in_shift = (state == SHIFT);

  // NOTE: in_ready looks only at hold_full, never at a same-cycle drain, and is forced low while reset is asserted.
  assign stream.in_ready = reset & !hold_full & !last_seen & (in_idle | in_shift);
  assign accept          = stream.in_valid & stream.in_ready;

  assign eng_bit   = in_shift & ser_bit;
  assign eng_reset = !reset | !(in_shift | (state == CAPTURE));
  assign busy      = !in_idle;

  crc_byte_serializer u_serializer (
    .clock     (clock),
    .reset     (reset),
    .clear     (state == ABORT),
    .load      (in_idle & accept),
    .push      (in_shift & accept),
    .advance   (in_shift),
    .data      (stream.in_data),
    .bit_out   (ser_bit),
    .last_bit  (last_bit),
    .hold_full (hold_full)
  );

  // NOTE: every branch reads pre-edge state, byte_cnt and last_seen; non-blocking updates keep that true.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      last_seen <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            byte_cnt  <= CNT_W'(1);
            last_seen <= stream.in_last;
          end
        end
        SHIFT: begin
          if (accept) begin
            byte_cnt  <= byte_cnt + 1'b1;
            last_seen <= last_seen | stream.in_last;
          end
          if (accept && (byte_cnt == MAX_CNT)) begin
            state <= ABORT;
            err   <= 1'b1;
          end else if (last_bit && !hold_full) begin
            if (last_seen) begin
              state <= CAPTURE;
            end else begin
              state <= ABORT;
              err   <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          crc_out <= eng_crc;
          crc_ok  <= (eng_crc == RESIDUE);
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          last_seen <= 1'b0;
          state     <= IDLE;
        end
        ABORT: begin
          last_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed self-checking bench for crc_frame_ctrl; the CRC engine is a stub driven by the bench.
module tb_crc_frame_ctrl;

  logic       clock;
  logic       reset;

  logic       eng_bit, eng_reset, crc_ok, done, err, busy;
  logic [7:0] eng_crc, crc_out;
  logic [6:0] byte_cnt;

  logic       o_bit, o_rst, o_ok, o_done, o_err, o_busy;
  logic [7:0] o_crc_in, o_crc_out;
  logic [1:0] o_cnt;

  int checks;
  int failures;

  logic [7:0]  fr_data [4];
  logic        fr_last [4];
  int          fr_n;
  logic [31:0] obs_stream;
  logic [31:0] obs_rst;
  int          done_cnt, done_first, done_last, err_cnt, err_first;
  logic [7:0]  done_crc;
  logic        done_ok;
  logic [6:0]  done_bcnt;

  crc_frame_ctrl_if s ();
  crc_frame_ctrl_if o ();

  crc_frame_ctrl #(.MAX_BYTES(64), .RESIDUE(8'h00)) dut (
    .clock(clock), .reset(reset), .stream(s),
    .eng_bit(eng_bit), .eng_reset(eng_reset), .eng_crc(eng_crc),
    .crc_out(crc_out), .crc_ok(crc_ok), .done(done), .err(err),
    .busy(busy), .byte_cnt(byte_cnt)
  );

  crc_frame_ctrl #(.MAX_BYTES(2), .RESIDUE(8'h00)) dut_ovf (
    .clock(clock), .reset(reset), .stream(o),
    .eng_bit(o_bit), .eng_reset(o_rst), .eng_crc(o_crc_in),
    .crc_out(o_crc_out), .crc_ok(o_ok), .done(o_done), .err(o_err),
    .busy(o_busy), .byte_cnt(o_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs ncyc cycles starting with cycle 0, offering fr_data[0..fr_n-1] whenever the DUT is ready.
  task automatic run_frame(input int ncyc);
    int idx;
    idx        = 0;
    obs_stream = '0;
    obs_rst    = '0;
    done_cnt   = 0;
    done_first = -1;
    done_last  = -1;
    err_cnt    = 0;
    err_first  = -1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (idx < fr_n) begin
        s.in_valid = 1'b1;
        s.in_data  = fr_data[idx];
        s.in_last  = fr_last[idx];
      end else begin
        s.in_valid = 1'b0;
        s.in_data  = 8'h00;
        s.in_last  = 1'b0;
      end
      @(negedge clock);
      if (cyc >= 1 && cyc <= 32) obs_stream = {obs_stream[30:0], eng_bit};
      if (cyc < 32) obs_rst[cyc] = eng_reset;
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = cyc;
        done_last = cyc;
        done_crc  = crc_out;
        done_ok   = crc_ok;
        done_bcnt = byte_cnt;
      end
      if (err) begin
        err_cnt++;
        if (err_first < 0) err_first = cyc;
      end
      if (s.in_valid && s.in_ready) idx++;
      @(posedge clock);
      #1;
    end
    s.in_valid = 1'b0;
    s.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (s.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", s.in_ready); end
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("FAIL reset_eng_reset got=%b exp=1", eng_reset); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, err, crc_ok, eng_bit, crc_out, byte_cnt} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, err, crc_ok, eng_bit, crc_out, byte_cnt});
    end
    checks++; if (s.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_idle got=%b exp=1", s.in_ready); end
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("FAIL reset_idle_eng_reset got=%b exp=1", eng_reset); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_ovf_busy got=%b exp=0", o_busy); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_residue();
    fr_data[0] = 8'h3A; fr_last[0] = 1'b1; fr_n = 1;
    eng_crc = 8'h00;
    run_frame(33);
    checks++; if (done_first !== 10) begin failures++; $display("FAIL residue_done_cycle got=%0d exp=10", done_first); end
    checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL residue_crc_ok got=%b exp=1", done_ok); end
    checks++; if (done_crc !== 8'h00) begin failures++; $display("FAIL residue_crc_out got=%h exp=00", done_crc); end
  endtask

  task automatic test_single_byte();
    fr_data[0] = 8'h5D; fr_last[0] = 1'b1; fr_n = 1;
    eng_crc = 8'hA7;
    run_frame(33);
    checks++; if (obs_stream !== 32'h5D00_0000) begin failures++; $display("FAIL single_stream got=%h exp=5d000000", obs_stream); end
    checks++; if (obs_rst !== 32'hFFFF_FC01) begin failures++; $display("FAIL single_eng_reset got=%h exp=fffffc01", obs_rst); end
    checks++; if (done_first !== 10) begin failures++; $display("FAIL single_done_cycle got=%0d exp=10", done_first); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_crc !== 8'hA7) begin failures++; $display("FAIL single_crc_out got=%h exp=a7", done_crc); end
    checks++; if (done_ok !== 1'b0) begin failures++; $display("FAIL single_crc_ok got=%b exp=0", done_ok); end
    checks++; if (done_bcnt !== 7'd1) begin failures++; $display("FAIL single_byte_cnt got=%0d exp=1", done_bcnt); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL single_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_three_byte();
    fr_data[0] = 8'hFF; fr_last[0] = 1'b0;
    fr_data[1] = 8'h00; fr_last[1] = 1'b0;
    fr_data[2] = 8'h81; fr_last[2] = 1'b1;
    fr_n = 3;
    eng_crc = 8'h3C;
    run_frame(33);
    checks++; if (obs_stream !== 32'hFF00_8100) begin failures++; $display("FAIL three_stream got=%h exp=ff008100", obs_stream); end
    checks++; if (obs_rst !== 32'hFC00_0001) begin failures++; $display("FAIL three_eng_reset got=%h exp=fc000001", obs_rst); end
    checks++; if (done_first !== 26) begin failures++; $display("FAIL three_done_cycle got=%0d exp=26", done_first); end
    checks++; if (done_bcnt !== 7'd3) begin failures++; $display("FAIL three_byte_cnt got=%0d exp=3", done_bcnt); end
    checks++; if (done_crc !== 8'h3C) begin failures++; $display("FAIL three_crc_out got=%h exp=3c", done_crc); end
  endtask

  task automatic test_underrun();
    fr_data[0] = 8'hC3; fr_last[0] = 1'b0; fr_n = 1;
    eng_crc = 8'h55;
    run_frame(33);
    checks++; if (obs_stream !== 32'hC300_0000) begin failures++; $display("FAIL underrun_stream got=%h exp=c3000000", obs_stream); end
    checks++; if (obs_rst !== 32'hFFFF_FE01) begin failures++; $display("FAIL underrun_eng_reset got=%h exp=fffffe01", obs_rst); end
    checks++; if (err_first !== 9) begin failures++; $display("FAIL underrun_err_cycle got=%0d exp=9", err_first); end
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL underrun_err_count got=%0d exp=1", err_cnt); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL underrun_done_count got=%0d exp=0", done_cnt); end
    checks++; if (crc_out !== 8'h3C) begin failures++; $display("FAIL underrun_crc_kept got=%h exp=3c", crc_out); end
  endtask

  task automatic test_back_to_back();
    fr_data[0] = 8'hA5; fr_last[0] = 1'b1;
    fr_data[1] = 8'h3C; fr_last[1] = 1'b1;
    fr_n = 2;
    eng_crc = 8'h5A;
    run_frame(33);
    checks++; if (obs_stream !== 32'hA507_8000) begin failures++; $display("FAIL b2b_stream got=%h exp=a5078000", obs_stream); end
    checks++; if (obs_rst !== 32'hFFE0_0C01) begin failures++; $display("FAIL b2b_eng_reset got=%h exp=ffe00c01", obs_rst); end
    checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    checks++; if (done_first !== 10) begin failures++; $display("FAIL b2b_first_done got=%0d exp=10", done_first); end
    checks++; if (done_last !== 21) begin failures++; $display("FAIL b2b_second_done got=%0d exp=21", done_last); end
    checks++; if (done_bcnt !== 7'd1) begin failures++; $display("FAIL b2b_byte_cnt got=%0d exp=1", done_bcnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [3];
    int         acc [3];
    int         exp_acc [3];
    int         idx, err_at, err_n, done_n;
    logic [1:0] cnt_at_err;
    logic       busy_after, ready_after;
    bytes   = '{8'h11, 8'h22, 8'h33};
    exp_acc = '{0, 1, 9};
    acc     = '{-1, -1, -1};
    idx = 0; err_at = -1; err_n = 0; done_n = 0;
    cnt_at_err = 2'd0; busy_after = 1'b1; ready_after = 1'b0;
    o_crc_in = 8'h00;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (idx < 3) begin
        o.in_valid = 1'b1;
        o.in_data  = bytes[idx];
      end else begin
        o.in_valid = 1'b0;
        o.in_data  = 8'h00;
      end
      o.in_last = 1'b0;
      @(negedge clock);
      if (o_err) begin
        err_n++;
        if (err_at < 0) begin
          err_at     = cyc;
          cnt_at_err = o_cnt;
        end
      end
      if (o_done) done_n++;
      if (cyc == 11) begin
        busy_after  = o_busy;
        ready_after = o.in_ready;
      end
      if (o.in_valid && o.in_ready) begin
        acc[idx] = cyc;
        idx++;
      end
      @(posedge clock);
      #1;
    end
    o.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (acc[i] !== exp_acc[i]) begin failures++; $display("FAIL ovf_accept_cycle[%0d] got=%0d exp=%0d", i, acc[i], exp_acc[i]); end
    end
    checks++; if (err_at !== 10) begin failures++; $display("FAIL ovf_err_cycle got=%0d exp=10", err_at); end
    checks++; if (err_n !== 1) begin failures++; $display("FAIL ovf_err_count got=%0d exp=1", err_n); end
    checks++; if (done_n !== 0) begin failures++; $display("FAIL ovf_done_count got=%0d exp=0", done_n); end
    checks++; if (cnt_at_err !== 2'd3) begin failures++; $display("FAIL ovf_byte_cnt got=%0d exp=3", cnt_at_err); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL ovf_idle_after got=%b exp=0", busy_after); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL ovf_ready_after got=%b exp=1", ready_after); end
  endtask

  task automatic test_mid_reset();
    s.in_valid = 1'b1; s.in_data = 8'hE7; s.in_last = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
    s.in_valid = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) begin
      @(negedge clock);
      if (cyc == 3) begin
        checks++; if ({busy, eng_bit} !== 2'b11) begin failures++; $display("FAIL midrst_frame_running got=%b exp=11", {busy, eng_bit}); end
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (s.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_in_reset got=%b exp=0", s.in_ready); end
    checks++; if (eng_reset !== 1'b1) begin failures++; $display("FAIL midrst_eng_reset_in_reset got=%b exp=1", eng_reset); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, err, crc_ok, eng_bit, crc_out, byte_cnt} !== 20'h0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h exp=0", {busy, done, err, crc_ok, eng_bit, crc_out, byte_cnt});
    end
    checks++; if ({eng_reset, s.in_ready} !== 2'b11) begin failures++; $display("FAIL midrst_idle_flags got=%b exp=11", {eng_reset, s.in_ready}); end
    @(posedge clock);
    #1;
    fr_data[0] = 8'h96; fr_last[0] = 1'b1; fr_n = 1;
    eng_crc = 8'h69;
    run_frame(33);
    checks++; if (obs_stream !== 32'h9600_0000) begin failures++; $display("FAIL midrst_new_stream got=%h exp=96000000", obs_stream); end
    checks++; if (done_first !== 10) begin failures++; $display("FAIL midrst_new_done got=%0d exp=10", done_first); end
    checks++; if ({done_crc, done_bcnt} !== {8'h69, 7'd1}) begin failures++; $display("FAIL midrst_new_result got=%h exp=%h", {done_crc, done_bcnt}, {8'h69, 7'd1}); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    s.in_valid = 1'b0; s.in_data = 8'h00; s.in_last = 1'b0;
    o.in_valid = 1'b0; o.in_data = 8'h00; o.in_last = 1'b0;
    eng_crc    = 8'h00;
    o_crc_in   = 8'h00;
    @(posedge clock);
    #1;
    test_reset();
    test_residue();
    test_single_byte();
    test_three_byte();
    test_underrun();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
- Sequences the bit-serial CRC-8 engine `crc`, which has ports CRC[7:0], bitval, clock and reset (active-high).
- Accepts a byte frame on a valid/ready stream and feeds it into the engine one bit per clock, MSB first.
- Owns the engine's reset, captures the final CRC and reports done, match or error.
- Sits between the packet source and the engine. The engine has no enable, so once a frame starts the controller supplies an uninterrupted bit stream or aborts the frame.

Parameters:
- MAX_BYTES, 64: maximum frame length in bytes; exceeding it aborts the frame.
- CNT_W, 7: byte counter width, equal to $clog2(MAX_BYTES+1).
- RESIDUE, 8'h00: CRC value reported as a match (used for residue checks on frames that end with their own CRC).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- in_data  in  8  frame byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  this byte is the last of the frame; qualified by in_valid.
- in_ready  out  1  controller can accept a byte.
- eng_bit  out  1  drives the engine's bitval.
- eng_reset  out  1  drives the engine's reset, active-high.
- eng_crc  in  8  from the engine's CRC.
- crc_out  out  8  captured CRC; held until the next capture.
- crc_ok  out  1  crc_out == RESIDUE; valid while done is high.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse when a frame aborts (underrun or overflow).
- busy  out  1  high in every state except IDLE.
- byte_cnt  out  CNT_W  bytes accepted in the current or last frame.

Behaviour:
- Reset (reset==0 at a clock edge), from any state including mid-frame:
  - state=IDLE, shift/hold registers and flags cleared.
  - crc_out=0, crc_ok=0, done=0, err=0, byte_cnt=0, eng_bit=0.
  - in_ready=0 during the reset cycle; eng_reset=1 (combinational).
- States: IDLE, SHIFT, CAPTURE, DONE, ABORT.
- eng_reset = 1 in IDLE, DONE and ABORT; 0 in SHIFT and CAPTURE. It is decoded from state and is safe for a sync or async engine reset.
- in_ready = hold_empty & !last_seen & (state==IDLE | state==SHIFT).
- IDLE:
  - An accepted byte loads the shift register directly, sets byte_cnt=1 and last_seen=in_last.
  - Next state is SHIFT, with bit_cnt=0.
- SHIFT:
  - eng_bit = shift[7]. Shift left each cycle; bit_cnt increments.
  - A byte accepted during SHIFT goes to the hold register and increments byte_cnt; last_seen |= in_last.
  - At bit_cnt==7:
    - hold full: move hold into shift, bit_cnt=0, stay in SHIFT (no bubble).
    - else if last_seen: go to CAPTURE.
    - else (underrun): go to ABORT.
  - Accepting byte MAX_BYTES+1 goes to ABORT at the next edge.
- CAPTURE (1 cycle):
  - Register eng_crc into crc_out.
  - Set crc_ok = (eng_crc == RESIDUE).
  - Next state is DONE.
- DONE (1 cycle): done=1, then IDLE.
- ABORT (1 cycle): err=1, hold cleared, then IDLE. crc_out is unchanged.
- Latency: first byte accepted in cycle 0 → bits presented in cycles 1..8 → CAPTURE in cycle 9 → done=1 in cycle 10.
  - An N-byte frame with no stall gives done at cycle 8N+2.
- A one-byte frame with in_last=1 is legal.
- in_last with in_ready=0 is ignored (no handshake took place).
- Back-to-back frames: the next frame can be accepted in IDLE after DONE. The minimum gap is 2 cycles with engine reset asserted.
- No simultaneous accept and drain of the hold register: in_ready uses hold_empty only. The producer has 7 cycles per byte to avoid underrun.

Decomposition:
- Package crc_ctrl_pkg holds:
  - the state enum (IDLE, SHIFT, CAPTURE, DONE, ABORT);
  - CRC_W=8 and BIT_CNT_W=3 constants.
- One natural sub-module: crc_byte_serializer, containing the shift register, hold register and bit counter, with a byte-in and bit-out interface. The FSM stays in the top.

Test Plan:
- Single byte 8'h5D with in_last=1, accepted at cycle 0:
  - eng_bit = 0,1,0,1,1,1,0,1 in cycles 1..8;
  - eng_reset = 0 in cycles 1..9;
  - with a stub engine driving eng_crc=8'hA7 in cycle 9: crc_out=8'hA7, crc_ok=0, done pulses in cycle 10, byte_cnt=1.
- Three-byte frame 8'hFF, 8'h00, 8'h81 with bytes offered whenever in_ready=1:
  - contiguous 24-bit stream on eng_bit with no bubble at byte boundaries;
  - done at cycle 26; byte_cnt=3.
- Residue check: stub engine returns 8'h00 in CAPTURE → crc_ok=1 during done.
- Underrun: first byte without in_last, second byte withheld → err pulses in cycle 9, done never asserts, eng_reset=1 from cycle 9, crc_out keeps its previous value.
- Overflow with MAX_BYTES=2: third byte accepted → err pulses one cycle later and the FSM returns to IDLE.
- reset=0 asserted for one cycle mid-SHIFT (cycle 4) → at the next cycle: IDLE, eng_reset=1, in_ready=1, all outputs zero. A new frame then runs correctly.
